// File: rtl/serial_msg_receiver.sv
// rtl/serial_msg_receiver.sv - receive side of the alarm serial link: frame capture, length check, link watchdog
//
// Purpose:
//   Shifts in one MSG_W-bit message per frame (send_in high for the whole frame,
//   data_in MSB first), accepts frames of exactly MSG_W bits, flags other lengths,
//   and raises link_lost after TIMEOUT enabled cycles without a good frame.
//
// Optional feature macro: MATCH_CONFIRM_EN
//   When defined, a good frame only updates msg if it equals the previously
//   received good frame (candidate). When undefined, no candidate register exists.
//
// Ports:
//   CLK        in   rising-edge clock shared with the sender
//   RST_N      in   asynchronous reset, active low
//   EN         in   receiver enable
//   send_in    in   frame-enable from the sender
//   data_in    in   serial data, one bit per CLK while send_in=1
//   msg        out  last accepted message
//   msg_valid  out  one-cycle pulse when msg is updated
//   frame_err  out  one-cycle pulse when a frame length differs from MSG_W
//   link_lost  out  level, watchdog has reached TIMEOUT
module serial_msg_receiver #(
    parameter int MSG_W   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             send_in,
    input  logic             data_in,
    output logic [MSG_W-1:0] msg,
    output logic             msg_valid,
    output logic             frame_err,
    output logic             link_lost
);

    // Bit counter must hold MSG_W+1 so over-long frames stay distinguishable.
    localparam int BC_W = $clog2(MSG_W + 2);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state_q;
    logic [MSG_W-1:0] shift_q;
    logic [BC_W-1:0]  bitcnt_q;
    logic [CNT_W-1:0] wdog_q;
    logic [MSG_W-1:0] msg_q;
    logic             msg_valid_q;
    logic             frame_err_q;
    logic             link_lost_q;
`ifdef MATCH_CONFIRM_EN
    logic [MSG_W-1:0] cand_q;
    logic             cand_vld_q;
`endif

    logic [MSG_W-1:0] shift_d;
    logic [CNT_W-1:0] wdog_d;
    logic             good_end;

    // Over-long frames keep shifting so only the last MSG_W bits survive.
    assign shift_d  = (shift_q << 1) | MSG_W'(data_in);
    assign wdog_d   = (wdog_q == CNT_W'(TIMEOUT)) ? wdog_q : wdog_q + 1'b1;
    assign good_end = (state_q == RECV) && !send_in && (bitcnt_q == BC_W'(MSG_W));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            wdog_q      <= '0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            link_lost_q <= 1'b0;
`ifdef MATCH_CONFIRM_EN
            cand_q      <= '0;
            cand_vld_q  <= 1'b0;
`endif
        end else begin
            msg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (!EN) begin
                // Disabled: abort any partial frame silently, keep msg.
                state_q     <= IDLE;
                bitcnt_q    <= '0;
                wdog_q      <= '0;
                link_lost_q <= 1'b0;
`ifdef MATCH_CONFIRM_EN
                cand_vld_q  <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (send_in) begin
                            shift_q  <= MSG_W'(data_in);
                            bitcnt_q <= BC_W'(1);
                            state_q  <= RECV;
                        end
                    end
                    RECV: begin
                        if (send_in) begin
                            shift_q <= shift_d;
                            if (bitcnt_q != BC_W'(MSG_W + 1)) begin
                                bitcnt_q <= bitcnt_q + 1'b1;
                            end
                        end else begin
                            state_q  <= IDLE;
                            bitcnt_q <= '0;
                            if (good_end) begin
`ifdef MATCH_CONFIRM_EN
                                if (cand_vld_q && (shift_q == cand_q)) begin
                                    msg_q       <= shift_q;
                                    msg_valid_q <= 1'b1;
                                end
                                cand_q     <= shift_q;
                                cand_vld_q <= 1'b1;
`else
                                msg_q       <= shift_q;
                                msg_valid_q <= 1'b1;
`endif
                            end else begin
                                frame_err_q <= 1'b1;
`ifdef MATCH_CONFIRM_EN
                                cand_vld_q  <= 1'b0;
`endif
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase

                // Only good frames feed the watchdog; errors let it keep counting.
                if (good_end) begin
                    wdog_q      <= '0;
                    link_lost_q <= 1'b0;
                end else begin
                    wdog_q      <= wdog_d;
                    link_lost_q <= (wdog_d == CNT_W'(TIMEOUT));
                end
            end
        end
    end

    assign msg       = msg_q;
    assign msg_valid = msg_valid_q;
    assign frame_err = frame_err_q;
    assign link_lost = link_lost_q;

endmodule

// File: tb/tb_serial_msg_receiver.sv
// tb/tb_serial_msg_receiver.sv - scoreboard bench for serial_msg_receiver
module tb_serial_msg_receiver;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       EN;
    logic       send_in;
    logic       data_in;
    logic [3:0] msg;
    logic       msg_valid;
    logic       frame_err;
    logic       link_lost;

    serial_msg_receiver #(.MSG_W(4), .TIMEOUT(64), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .EN        (EN),
        .send_in   (send_in),
        .data_in   (data_in),
        .msg       (msg),
        .msg_valid (msg_valid),
        .frame_err (frame_err),
        .link_lost (link_lost)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         err;
        logic [3:0] m;
    } ev_t;

    ev_t        exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_msg = 4'h0;
    logic [3:0] cand    = 4'h0;
    bit         cand_v  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model of the frame end outcome; pushes the expected output event (if any).
    task automatic expect_end(input logic [7:0] bits, input int len);
        ev_t e;
        if (len != 4) begin
            e.err = 1'b1; e.m = exp_msg;
            exp_q.push_back(e);
            cand_v = 1'b0;
        end else begin
`ifdef MATCH_CONFIRM_EN
            if (cand_v && cand == bits[3:0]) begin
                exp_msg = bits[3:0];
                e.err = 1'b0; e.m = exp_msg;
                exp_q.push_back(e);
            end
            cand = bits[3:0];
            cand_v = 1'b1;
`else
            exp_msg = bits[3:0];
            e.err = 1'b0; e.m = exp_msg;
            exp_q.push_back(e);
`endif
        end
    endtask

    // Entered and left at posedge+1; leaves one low cycle after the frame.
    task automatic frame(input logic [7:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            send_in = 1'b1;
            data_in = bits[i];
            @(posedge CLK); #1;
        end
        send_in = 1'b0;
        data_in = 1'b0;
        expect_end(bits, len);
        @(posedge CLK); #1;
    endtask

    // Monitor: compares every output pulse against the scoreboard.
    initial begin
        ev_t e;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1) begin
                if (msg_valid && frame_err) chk("pulse_overlap", 1, 0);
                if (msg_valid || frame_err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {30'd0, msg_valid, frame_err}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_err", {31'd0, frame_err}, {31'd0, e.err});
                        chk("msg_valid", {31'd0, msg_valid}, {31'd0, ~e.err});
                        chk("msg", {28'd0, msg}, {28'd0, e.m});
                    end
                end
            end
        end
    end

    initial begin
        RST_N = 1'b0; EN = 1'b0; send_in = 1'b0; data_in = 1'b0;
        repeat (3) @(posedge CLK); #1;
        chk("rst_msg", {28'd0, msg}, 0);
        chk("rst_msg_valid", {31'd0, msg_valid}, 0);
        chk("rst_frame_err", {31'd0, frame_err}, 0);
        chk("rst_link_lost", {31'd0, link_lost}, 0);
        RST_N = 1'b1; EN = 1'b1;
        @(posedge CLK); #1;

        // good, short, long, then good one low cycle later
        frame(8'b1011, 4);
        chk("msg_after_1011", {28'd0, msg}, {28'd0, exp_msg});
        frame(8'b101, 3);
        frame(8'b11010, 5);
        frame(8'b0110, 4);
        chk("msg_after_0110", {28'd0, msg}, {28'd0, exp_msg});

        // watchdog: zero on the last good edge, saturates at 64
        repeat (63) @(posedge CLK); #1;
        chk("link_lost_63", {31'd0, link_lost}, 0);
        @(posedge CLK); #1;
        chk("link_lost_64", {31'd0, link_lost}, 1);
        frame(8'b0001, 4);
        chk("link_lost_clear", {31'd0, link_lost}, 0);

        // EN falls mid-frame: silent abort
        send_in = 1'b1; data_in = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        EN = 1'b0; data_in = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        send_in = 1'b0;
        cand_v = 1'b0;
        @(posedge CLK); #1;
        chk("en_off_msg_held", {28'd0, msg}, {28'd0, exp_msg});
        chk("en_off_link_lost", {31'd0, link_lost}, 0);

        // EN rises after first bit of 1011: short frame
        send_in = 1'b1; data_in = 1'b1;
        @(posedge CLK); #1;
        EN = 1'b1; data_in = 1'b0;
        @(posedge CLK); #1;
        data_in = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        send_in = 1'b0; data_in = 1'b0;
        expect_end(8'b011, 3);
        @(posedge CLK); #1;

        // async reset after two bits of a frame
        send_in = 1'b1; data_in = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_N = 1'b0; send_in = 1'b0; data_in = 1'b0;
        exp_msg = 4'h0; cand_v = 1'b0;
        #1;
        chk("midrst_msg", {28'd0, msg}, 0);
        chk("midrst_msg_valid", {31'd0, msg_valid}, 0);
        chk("midrst_frame_err", {31'd0, frame_err}, 0);
        chk("midrst_link_lost", {31'd0, link_lost}, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        frame(8'b1110, 4);
        chk("msg_after_1110", {28'd0, msg}, {28'd0, exp_msg});

`ifdef MATCH_CONFIRM_EN
        frame(8'b0110, 4);
        frame(8'b0111, 4);
        chk("confirm_not_yet", {28'd0, msg}, {28'd0, exp_msg});
        frame(8'b0111, 4);
        chk("confirm_msg", {28'd0, msg}, 32'h7);
`else
        frame(8'b0111, 4);
        chk("msg_after_0111", {28'd0, msg}, 32'h7);
`endif

        repeat (3) @(posedge CLK); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
